// File: rtl/feature_fetch_ctrl_if.sv
// Bundles the fetch-job control, SRAM read port and feature-loader write port
// of feature_fetch_ctrl; master is the controller side, slave the environment.
interface feature_fetch_ctrl_if #(
  parameter int inputWidth   = 256,
  parameter int addrWidth    = 8,
  parameter int elementWidth = 8,
  parameter int numElements  = 128,
  parameter int memAddrWidth = 16
) ();
  // job control
  logic                    start_i;
  logic [memAddrWidth-1:0] base_addr_i;
  logic [addrWidth:0]      num_elems_i;
  logic                    abort_i;
  // SRAM read port
  logic                    mem_req_o;
  logic [memAddrWidth-1:0] mem_addr_o;
  logic                    mem_gnt_i;
  logic                    mem_rvalid_i;
  logic [inputWidth-1:0]   mem_rdata_i;
  // feature-loader write port
  logic                    fl_wr_en_o;
  logic [addrWidth-1:0]    fl_addr_o;
  logic [inputWidth-1:0]   fl_data_o;
  // status
  logic                    busy_o;
  logic                    done_o;
  logic                    err_o;

  modport master (
    input  start_i, base_addr_i, num_elems_i, abort_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output mem_req_o, mem_addr_o,
    output fl_wr_en_o, fl_addr_o, fl_data_o,
    output busy_o, done_o, err_o
  );

  modport slave (
    output start_i, base_addr_i, num_elems_i, abort_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o,
    input  fl_wr_en_o, fl_addr_o, fl_data_o,
    input  busy_o, done_o, err_o
  );
endinterface

// File: rtl/feature_fetch_ctrl.sv
// Fetches ceil(num_elems/EPW) SRAM words one request at a time into the feature loader.
// Define FEATURE_FETCH_ZERO_PAD_EN to zero the unused tail lanes of the last word.
module feature_fetch_ctrl #(
  parameter int inputWidth   = 256,
  parameter int addrWidth    = 8,
  parameter int elementWidth = 8,
  parameter int numElements  = 128,
  parameter int memAddrWidth = 16
) (
  input  logic clk,
  input  logic nrst,
  feature_fetch_ctrl_if.master bus
);
  localparam int EPW = inputWidth / elementWidth;
  localparam int CW  = addrWidth + 1;
  localparam logic [CW-1:0] EPW_C = CW'(EPW);
  localparam logic [CW-1:0] MAX_C = CW'(numElements);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DRAIN} state_t;

  state_t                  state_reg;
  logic [CW-1:0]           w_reg;
  logic [CW-1:0]           words_reg;
  logic [memAddrWidth-1:0] mem_addr_reg;
  logic                    mem_req_reg;
  logic                    wr_en_reg;
  logic                    done_reg;
  logic                    err_reg;
  logic [addrWidth-1:0]    fl_addr_reg;
  logic [inputWidth-1:0]   data_reg;

  logic                    start_ok;
  logic                    last_word;
  logic [CW-1:0]           w_next;
  logic [inputWidth-1:0]   word_in;

  assign start_ok  = (bus.num_elems_i != '0) && (bus.num_elems_i <= MAX_C);
  assign w_next    = w_reg + CW'(1);
  assign last_word = (w_next == words_reg);

`ifdef FEATURE_FETCH_ZERO_PAD_EN
  logic [CW-1:0]         rem_reg;
  logic [inputWidth-1:0] keep_mask;

  // Lane 0 sits in the MSBs; only the final word of a ragged job is trimmed.
  generate
    for (genvar gi = 0; gi < EPW; gi++) begin : g_lane
      assign keep_mask[inputWidth-1-gi*elementWidth -: elementWidth] =
        {elementWidth{!last_word || (rem_reg == '0) || (CW'(gi) < rem_reg)}};
    end
  endgenerate

  assign word_in = bus.mem_rdata_i & keep_mask;
`else
  assign word_in = bus.mem_rdata_i;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg    <= IDLE;
      w_reg        <= '0;
      words_reg    <= '0;
      mem_addr_reg <= '0;
      mem_req_reg  <= 1'b0;
      wr_en_reg    <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      fl_addr_reg  <= '0;
      data_reg     <= '0;
`ifdef FEATURE_FETCH_ZERO_PAD_EN
      rem_reg      <= '0;
`endif
    end else begin
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start_i) begin
            if (start_ok) begin
              words_reg    <= (bus.num_elems_i + EPW_C - CW'(1)) / EPW_C;
              w_reg        <= '0;
              mem_addr_reg <= bus.base_addr_i;
              mem_req_reg  <= 1'b1;
              state_reg    <= REQ;
`ifdef FEATURE_FETCH_ZERO_PAD_EN
              rem_reg      <= bus.num_elems_i % EPW_C;
`endif
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus.abort_i) begin
            // A grant taken together with the abort still owes us a response.
            mem_req_reg <= 1'b0;
            state_reg   <= bus.mem_gnt_i ? DRAIN : IDLE;
          end else if (bus.mem_gnt_i) begin
            mem_req_reg <= 1'b0;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.abort_i) begin
            state_reg <= bus.mem_rvalid_i ? IDLE : DRAIN;
          end else if (bus.mem_rvalid_i) begin
            data_reg    <= word_in;
            fl_addr_reg <= addrWidth'(w_reg * EPW_C);
            wr_en_reg   <= 1'b1;
            done_reg    <= last_word;
            state_reg   <= WRITE;
          end
        end
        WRITE: begin
          if (bus.abort_i) begin
            state_reg <= IDLE;
          end else begin
            w_reg <= w_next;
            if (last_word) begin
              state_reg <= IDLE;
            end else begin
              mem_addr_reg <= mem_addr_reg + memAddrWidth'(1);
              mem_req_reg  <= 1'b1;
              state_reg    <= REQ;
            end
          end
        end
        DRAIN: begin
          if (bus.mem_rvalid_i) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // An abort during WRITE suppresses the write and done already staged for this cycle.
  assign bus.fl_wr_en_o = wr_en_reg & ~bus.abort_i;
  assign bus.done_o     = done_reg & ~bus.abort_i;
  assign bus.err_o      = err_reg;
  assign bus.mem_req_o  = mem_req_reg;
  assign bus.mem_addr_o = mem_addr_reg;
  assign bus.fl_addr_o  = fl_addr_reg;
  assign bus.fl_data_o  = data_reg;
  assign bus.busy_o     = (state_reg != IDLE);
endmodule

// File: tb/tb_feature_fetch_ctrl.sv
// Directed and randomized checks of feature_fetch_ctrl against a word-level
// SRAM/loader model; the padding expectation follows FEATURE_FETCH_ZERO_PAD_EN.
module tb_feature_fetch_ctrl;
  localparam int IW  = 256;
  localparam int AW  = 8;
  localparam int EW  = 8;
  localparam int NE  = 128;
  localparam int MW  = 16;
  localparam int EPW = IW / EW;
`ifdef FEATURE_FETCH_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic clk;
  logic nrst;

  feature_fetch_ctrl_if #(.inputWidth(IW), .addrWidth(AW), .elementWidth(EW),
                          .numElements(NE), .memAddrWidth(MW)) bus ();

  feature_fetch_ctrl #(.inputWidth(IW), .addrWidth(AW), .elementWidth(EW),
                       .numElements(NE), .memAddrWidth(MW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int gnt_dly = 0;
  int rv_dly  = 0;
  logic [31:0] seed = 32'h0;
  bit mon_clr = 1'b0;

  // monitor results
  logic [AW-1:0] wr_addr_q[$];
  logic [IW-1:0] wr_data_q[$];
  logic [MW-1:0] gaddr_q[$];
  int done_n, err_n, req_n, busy_n, unstable_n, done_cyc;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SRAM content as a pure function of address and per-job seed
  function automatic logic [IW-1:0] word_of(input logic [MW-1:0] a);
    logic [IW-1:0] r;
    for (int k = 0; k < IW / 32; k++)
      r[k*32 +: 32] = ({16'h0, a} * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA6B) ^ seed;
    return r;
  endfunction

  function automatic logic [IW-1:0] expect_word(input logic [MW-1:0] a, input int k,
                                                input int nw, input int n);
    logic [IW-1:0] r;
    int rem;
    r   = word_of(a);
    rem = n % EPW;
    if (PAD_EN && k == nw - 1 && rem != 0)
      for (int j = rem; j < EPW; j++) r[IW-1-EW*j -: EW] = '0;
    return r;
  endfunction

  // SRAM: grant after gnt_dly cycles of request, data gnt-cycle + 1 + rv_dly
  initial begin
    int req_age;
    bit rv_pend;
    int rv_cnt;
    logic [MW-1:0] rv_addr, g_addr;
    req_age = 0; rv_pend = 0; rv_cnt = 0; rv_addr = '0; g_addr = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_gnt_i) begin
        rv_pend = 1; rv_cnt = rv_dly; rv_addr = g_addr;
      end
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = word_of(rv_addr);
          rv_pend = 0;
        end else begin
          rv_cnt--;
        end
      end
      if (bus.mem_req_o) begin
        if (req_age >= gnt_dly) begin
          bus.mem_gnt_i = 1'b1;
          g_addr  = bus.mem_addr_o;
          req_age = 0;
        end else begin
          req_age++;
        end
      end else begin
        req_age = 0;
      end
    end
  end

  initial begin
    logic prev_req;
    logic [MW-1:0] prev_addr;
    prev_req = 0; prev_addr = '0;
    done_n = 0; err_n = 0; req_n = 0; busy_n = 0; unstable_n = 0; done_cyc = -1;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        wr_addr_q.delete(); wr_data_q.delete(); gaddr_q.delete();
        done_n = 0; err_n = 0; req_n = 0; busy_n = 0; unstable_n = 0; done_cyc = -1;
      end else begin
        if (bus.fl_wr_en_o) begin
          wr_addr_q.push_back(bus.fl_addr_o);
          wr_data_q.push_back(bus.fl_data_o);
        end
        if (bus.done_o) begin done_n++; done_cyc = cyc; end
        if (bus.err_o) err_n++;
        if (bus.mem_req_o) req_n++;
        if (bus.busy_o) busy_n++;
        if (bus.mem_req_o && prev_req && bus.mem_addr_o != prev_addr) unstable_n++;
        if (bus.mem_req_o && bus.mem_gnt_i) gaddr_q.push_back(bus.mem_addr_o);
      end
      prev_req  = bus.mem_req_o;
      prev_addr = bus.mem_addr_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wide(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_req"},  64'(bus.mem_req_o),  64'h0);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr_o), 64'h0);
    check({tag, "_wr_en"},    64'(bus.fl_wr_en_o), 64'h0);
    check({tag, "_fl_addr"},  64'(bus.fl_addr_o),  64'h0);
    check_wide({tag, "_fl_data"}, bus.fl_data_o, '0);
    check({tag, "_busy"},     64'(bus.busy_o),     64'h0);
    check({tag, "_done"},     64'(bus.done_o),     64'h0);
    check({tag, "_err"},      64'(bus.err_o),      64'h0);
  endtask

  task automatic start_job(input logic [MW-1:0] base, input int n);
    bus.base_addr_i = base;
    bus.num_elems_i = (AW+1)'(n);
    bus.start_i     = 1'b1;
  endtask

  task automatic run_job(input string tag, input logic [MW-1:0] base, input int n,
                         input int gd, input int rd, input bit extra_start, output int lat);
    int nw, budget, st, nchk;
    gnt_dly = gd;
    rv_dly  = rd;
    seed    = $urandom;
    clear_mon();
    nw = (n + EPW - 1) / EPW;
    start_job(base, n);
    st = cyc;
    step(1);
    bus.start_i = 1'b0;
    budget = 0;
    while (done_n == 0 && budget < 400) begin
      if (extra_start && budget == 3) begin
        bus.base_addr_i = base ^ 16'h5A5A;
        bus.num_elems_i = (AW+1)'(7);
        bus.start_i     = 1'b1;
      end else begin
        bus.start_i = 1'b0;
      end
      step(1);
      budget++;
    end
    bus.start_i = 1'b0;
    step(1);
    $display("job %s base=%04h n=%0d gnt_dly=%0d rv_dly=%0d writes=%0d", tag, base, n, gd, rd,
             wr_addr_q.size());
    check({tag, "_finished"},  64'(budget < 400), 64'h1);
    check({tag, "_done_cnt"},  64'(done_n), 64'h1);
    check({tag, "_wr_cnt"},    64'(wr_addr_q.size()), 64'(nw));
    check({tag, "_gnt_cnt"},   64'(gaddr_q.size()), 64'(nw));
    check({tag, "_addr_hold"}, 64'(unstable_n), 64'h0);
    check({tag, "_busy_end"},  64'(bus.busy_o), 64'h0);
    nchk = (wr_addr_q.size() < nw) ? wr_addr_q.size() : nw;
    for (int k = 0; k < nchk; k++) begin
      check($sformatf("%s_fl_addr[%0d]", tag, k), 64'(wr_addr_q[k]), 64'(AW'(k * EPW)));
      check_wide($sformatf("%s_fl_data[%0d]", tag, k), wr_data_q[k],
                 expect_word(MW'(base + MW'(k)), k, nw, n));
    end
    nchk = (gaddr_q.size() < nw) ? gaddr_q.size() : nw;
    for (int k = 0; k < nchk; k++)
      check($sformatf("%s_mem_addr[%0d]", tag, k), 64'(gaddr_q[k]), 64'(MW'(base + MW'(k))));
    lat = done_cyc - st;
  endtask

  initial begin
    int lat;
    int bad_n[2];
    nrst = 1'b0;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.base_addr_i = '0;
    bus.num_elems_i = '0;
    step(3);
    check_outputs_zero("reset");
    nrst = 1'b1;
    step(2);

    // full-capacity job, zero-wait SRAM
    run_job("full", 16'h0100, 128, 0, 0, 1'b0, lat);
    check("full_done_latency", 64'(lat), 64'd12);

    // ragged job: padding depends on build
    run_job("ragged40", MW'($urandom), 40, 0, 0, 1'b0, lat);

    // illegal sizes
    bad_n[0] = 0;
    bad_n[1] = NE + 1;
    for (int i = 0; i < 2; i++) begin
      clear_mon();
      start_job(MW'($urandom), bad_n[i]);
      step(1);
      bus.start_i = 1'b0;
      check($sformatf("bad%0d_err_pulse", bad_n[i]), 64'(bus.err_o), 64'h1);
      step(1);
      check($sformatf("bad%0d_err_clear", bad_n[i]), 64'(bus.err_o), 64'h0);
      step(4);
      $display("job bad n=%0d err=%0d req=%0d busy=%0d", bad_n[i], err_n, req_n, busy_n);
      check($sformatf("bad%0d_err_cnt", bad_n[i]), 64'(err_n), 64'h1);
      check($sformatf("bad%0d_no_req", bad_n[i]),  64'(req_n), 64'h0);
      check($sformatf("bad%0d_no_busy", bad_n[i]), 64'(busy_n), 64'h0);
    end

    // slow SRAM, with a start pulse during the job that must be ignored
    run_job("slow", MW'($urandom), 100, 5, 3, 1'b1, lat);

    // abort in WAIT: drain the late response, no write, no done
    gnt_dly = 0;
    rv_dly  = 4;
    clear_mon();
    start_job(MW'($urandom), 64);
    step(1);
    bus.start_i = 1'b0;
    step(1);
    bus.abort_i = 1'b1;
    step(1);
    bus.abort_i = 1'b0;
    step(2);
    check("drain_busy", 64'(bus.busy_o), 64'h1);
    step(2);
    check("drain_idle", 64'(bus.busy_o), 64'h0);
    step(3);
    $display("job abort_wait writes=%0d done=%0d", wr_addr_q.size(), done_n);
    check("drain_no_wr",   64'(wr_addr_q.size()), 64'h0);
    check("drain_no_done", 64'(done_n), 64'h0);
    run_job("after_drain", MW'($urandom), 32, 0, 0, 1'b0, lat);

    // abort in REQ before any grant
    gnt_dly = 5;
    rv_dly  = 0;
    clear_mon();
    start_job(MW'($urandom), 50);
    step(2);
    bus.start_i = 1'b0;
    check("abreq_req_before", 64'(bus.mem_req_o), 64'h1);
    bus.abort_i = 1'b1;
    step(1);
    bus.abort_i = 1'b0;
    check("abreq_req_low", 64'(bus.mem_req_o), 64'h0);
    check("abreq_idle",    64'(bus.busy_o), 64'h0);
    step(8);
    $display("job abort_req writes=%0d grants=%0d done=%0d", wr_addr_q.size(), gaddr_q.size(), done_n);
    check("abreq_no_wr",   64'(wr_addr_q.size()), 64'h0);
    check("abreq_no_gnt",  64'(gaddr_q.size()), 64'h0);
    check("abreq_no_done", 64'(done_n), 64'h0);

    // address wrap
    run_job("wrap", 16'hFFFF, 64, 1, 1, 1'b0, lat);

    // randomized jobs
    for (int i = 0; i < 4; i++)
      run_job($sformatf("rand%0d", i), MW'($urandom), $urandom_range(1, NE),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, lat);

    // reset mid-job while a response is pending
    gnt_dly = 0;
    rv_dly  = 3;
    clear_mon();
    start_job(MW'($urandom), 128);
    step(1);
    bus.start_i = 1'b0;
    step(8);
    nrst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    step(2);
    nrst = 1'b1;
    step(10);
    $display("job reset_mid writes=%0d grants=%0d done=%0d", wr_addr_q.size(), gaddr_q.size(), done_n);
    check("midrst_wr_cnt",  64'(wr_addr_q.size()), 64'h1);
    check("midrst_no_done", 64'(done_n), 64'h0);
    check("midrst_idle",    64'(bus.busy_o), 64'h0);
    check("midrst_no_req",  64'(bus.mem_req_o), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
